dct_accum_bank: RTL and testbench
=================================

Name: dct_accum_bank

Overview:
- Parametrised successor to the single-channel DCT accumulator in the MFCC cepstrum stage.
- Accumulates N_CH independent DCT coefficient sums over N_TERMS mel-filter products per frame, with channel-interleaved input.
- Emits one rounded, optionally saturated, fixed-point cepstral coefficient per channel, with a valid strobe, channel index and frame-done pulse.
- Sits between the DCT multiplier and the cepstral lifter/output buffer.

Parameters:
- IN_W, 23: signed product input width.
- ACC_W, 34: signed accumulator width. Must satisfy ACC_W >= IN_W + clog2(N_TERMS).
- OUT_W, 16: signed output width.
- OUT_LSB, 8: accumulator bit mapped to output LSB. Must satisfy OUT_LSB >= 1 and OUT_LSB + OUT_W <= ACC_W.
- N_CH, 13: number of DCT coefficients (channels).
- N_TERMS, 26: products summed per channel per frame.
- ROUND_EN, 1: 1 = round half up at OUT_LSB; 0 = truncate (floor).
- SAT_EN, 1: 1 = clamp to OUT_W signed range; 0 = keep low OUT_W bits (wrap).

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: in_data valid this cycle.
- in_start, in, 1: qualifies with in_valid; marks first sample of a frame (term 0, channel 0).
- in_data, in, IN_W: signed product.
- out_valid, out, 1: one-cycle result strobe.
- out_ch, out, CH_W: channel of out_data. CH_W = max(1, clog2(N_CH)).
- out_data, out, OUT_W: signed coefficient.
- frame_done, out, 1: pulses with out_valid for channel N_CH-1.
- ovf_sticky, out, 1: accumulator signed overflow seen in current/last frame.
- drop_err, out, 1: one-cycle pulse when in_valid arrives in IDLE without in_start.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; ch_cnt = 0, term_cnt = 0.
  - All accumulators 0.
  - out_valid, out_ch, out_data, frame_done, ovf_sticky and drop_err all 0.
- Input order: term-major, channel-minor. Sample k maps to term = k / N_CH, channel = k % N_CH.
- Cycles with in_valid=0 are stalls: counters, accumulators and state hold; no output strobe.
- State machine:
  - IDLE: in_valid & in_start goes to ACCUM. acc[0] loads sign-extend(in_data), ch_cnt=1 (or term_cnt advances if N_CH=1), ovf_sticky cleared.
  - IDLE: in_valid & ~in_start means the sample is dropped and drop_err pulses on the next cycle.
  - ACCUM, term 0: acc[ch] loads sign-extend(in_data).
  - ACCUM, term > 0: acc[ch] = acc[ch] + sign-extend(in_data), mod 2^ACC_W.
  - Counter advance: ch_cnt wraps N_CH-1 to 0 and increments term_cnt.
  - ACCUM, last sample of frame (term N_TERMS-1, ch N_CH-1): returns to IDLE, counters go to 0.
  - ACCUM, in_valid & in_start: abort the current frame and restart exactly as from IDLE. The aborted frame produces no further out_valid or frame_done.
- Overflow: ovf_sticky is set when an add changes sign with both operands of equal sign. It holds until the next accepted in_start.
- Output path, term N_TERMS-1 samples only:
  - sum = acc[ch] + in_data (the final sum, not the stored value).
  - r = sum + (ROUND_EN ? 2^(OUT_LSB-1) : 0), computed in ACC_W+1 bits.
  - s = r >>> OUT_LSB (arithmetic shift).
  - SAT_EN=1: clamp s to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. SAT_EN=0: take s[OUT_W-1:0].
  - Registered: out_valid, out_ch, out_data appear exactly 1 cycle after the accepting edge.
  - out_data and out_ch hold their last values when out_valid=0.
- Channel output spacing: results stream channel 0..N_CH-1, spaced by in_valid spacing. Back-to-back input gives N_CH consecutive strobes.
- New frame: in_start may arrive the cycle after the final sample. Accumulation of the new frame and output of the old final channel overlap without conflict.
- Reset mid-frame: immediately clears everything; the partial frame is discarded.

Test Plan:
- Reset: assert rst_n=0 mid-ACCUM with out_valid high -> all outputs 0 same cycle; next frame starts clean.
- N_CH=1, N_TERMS=3, ROUND_EN=0, SAT_EN=0: inputs 256, 512, -256 (start on first) -> one out_valid 1 cycle after third, out_data=2, out_ch=0, frame_done=1.
- Rounding, N_CH=1, N_TERMS=2, ROUND_EN=1: 256+128 -> out 2; -256+(-128) -> out -1; 256+127 -> out 1.
- Saturation, N_CH=1, N_TERMS=3: in_data=4194303 x3 (sum 12582909) -> SAT_EN=1 gives out 32767; SAT_EN=0 gives out -16385 (0xBFFF).
- Defaults (13x26), back-to-back: channel c fed c*256 every term -> 13 consecutive strobes, out_ch 0..12, out_data=26*c, frame_done only with ch 12. Repeat with random in_valid gaps -> identical results.
- Protocol errors:
  - in_valid without start in IDLE -> drop_err pulse, no state change.
  - in_start at term 10 -> old frame produces no output; new frame's results are correct.

Source files
------------

// File: rtl/dct_accum_bank.sv
// dct_accum_bank: multi-channel DCT coefficient accumulator for the MFCC
// cepstrum stage. Products arrive term-major / channel-minor; each channel
// sums N_TERMS products per frame and emits one rounded, optionally
// saturated coefficient when its final term arrives.
module dct_accum_bank #(
    parameter int IN_W     = 23,
    parameter int ACC_W    = 34,
    parameter int OUT_W    = 16,
    parameter int OUT_LSB  = 8,
    parameter int N_CH     = 13,
    parameter int N_TERMS  = 26,
    parameter int ROUND_EN = 1,
    parameter int SAT_EN   = 1,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_start,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    frame_done,
    output logic                    ovf_sticky,
    output logic                    drop_err
);

    localparam int TERM_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    logic [0:0]              state;
    logic [CH_W-1:0]         ch_cnt;
    logic [TERM_W-1:0]       term_cnt;
    logic signed [ACC_W-1:0] acc [N_CH];

    logic                    start_p0;
    logic                    accept_p0;
    logic                    first_term_p0;
    logic                    last_term_p0;
    logic                    last_ch_p0;
    logic                    ovf_add_p0;
    logic [CH_W-1:0]         ch_p0;
    logic [TERM_W-1:0]       term_p0;
    logic signed [ACC_W-1:0] din_p0;
    logic signed [ACC_W-1:0] cur_p0;
    logic signed [ACC_W-1:0] sum_p0;
    logic signed [ACC_W-1:0] acc_nxt_p0;

    // Round half up (or floor) at OUT_LSB in ACC_W+1 bits, then shift down.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] r;
        logic signed [ACC_W:0] half;
        half = '0;
        if (ROUND_EN != 0) half[OUT_LSB-1] = 1'b1;
        r = {v[ACC_W-1], v} + half;
        return r >>> OUT_LSB;
    endfunction

    // Clamp to the signed OUT_W range, or wrap to the low OUT_W bits.
    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] s);
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        hi = '0;
        hi[OUT_W-2:0] = '1;
        lo = ~hi;
        if ((SAT_EN != 0) && (s > hi)) return hi[OUT_W-1:0];
        if ((SAT_EN != 0) && (s < lo)) return lo[OUT_W-1:0];
        return s[OUT_W-1:0];
    endfunction

    // Stage p0: resolve the sample position (a start forces term 0 / ch 0) and form the new sum.
    always_comb begin
        start_p0      = in_valid & in_start;
        accept_p0     = in_valid & (in_start | (state == ACCUM));
        ch_p0         = start_p0 ? '0 : ch_cnt;
        term_p0       = start_p0 ? '0 : term_cnt;
        first_term_p0 = (term_p0 == '0);
        last_term_p0  = (term_p0 == TERM_W'(N_TERMS - 1));
        last_ch_p0    = (ch_p0 == CH_W'(N_CH - 1));
        din_p0        = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
        cur_p0        = acc[ch_p0];
        sum_p0        = cur_p0 + din_p0;
        ovf_add_p0    = ~first_term_p0 & (cur_p0[ACC_W-1] == din_p0[ACC_W-1])
                        & (sum_p0[ACC_W-1] != cur_p0[ACC_W-1]);
        acc_nxt_p0    = first_term_p0 ? din_p0 : sum_p0;
    end

    // Frame state, position counters, overflow flag and drop detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch_cnt     <= '0;
            term_cnt   <= '0;
            ovf_sticky <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            drop_err <= in_valid & ~in_start & (state == IDLE);
            if (accept_p0) begin
                ovf_sticky <= (ovf_sticky & ~start_p0) | ovf_add_p0;
                if (last_term_p0 && last_ch_p0) begin
                    state    <= IDLE;
                    ch_cnt   <= '0;
                    term_cnt <= '0;
                end else begin
                    state <= ACCUM;
                    if (last_ch_p0) begin
                        ch_cnt   <= '0;
                        term_cnt <= term_p0 + TERM_W'(1);
                    end else begin
                        ch_cnt   <= ch_p0 + CH_W'(1);
                        term_cnt <= term_p0;
                    end
                end
            end
        end
    end

    // Per-channel accumulators: load on term 0, add otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) acc[i] <= '0;
        end else if (accept_p0) begin
            acc[ch_p0] <= acc_nxt_p0;
        end
    end

    // Stage p1: register the finished coefficient one cycle after its final term.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= accept_p0 & last_term_p0;
            frame_done <= accept_p0 & last_term_p0 & last_ch_p0;
            if (accept_p0 && last_term_p0) begin
                out_ch   <= ch_p0;
                out_data <= saturate(round_shift(acc_nxt_p0));
            end
        end
    end

endmodule

// File: tb/tb_dct_accum_bank.sv
// Testbench for dct_accum_bank: a default-sized instance checked against a
// frame-level reference model, plus three single-channel instances driven
// from a table of short frames for rounding/saturation corner cases.
module tb_dct_accum_bank;

    localparam int N_CH    = 13;
    localparam int N_TERMS = 26;
    localparam int NS      = N_CH * N_TERMS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // main (default) instance
    logic               m_valid = 1'b0;
    logic               m_start = 1'b0;
    logic signed [22:0] m_data  = '0;
    logic               m_ov, m_fd, m_ovf, m_drop;
    logic [3:0]         m_ch;
    logic signed [15:0] m_out;

    dct_accum_bank dut (
        .clk(clk), .rst_n(rst_n), .in_valid(m_valid), .in_start(m_start), .in_data(m_data),
        .out_valid(m_ov), .out_ch(m_ch), .out_data(m_out), .frame_done(m_fd),
        .ovf_sticky(m_ovf), .drop_err(m_drop)
    );

    // shared bus for single-channel instances
    logic               s_valid = 1'b0;
    logic               s_start = 1'b0;
    logic signed [22:0] s_data  = '0;
    logic               a_ov, a_fd, a_ovf, a_drop, a_ch;
    logic               b_ov, b_fd, b_ovf, b_drop, b_ch;
    logic               c_ov, c_fd, c_ovf, c_drop, c_ch;
    logic signed [15:0] a_out, b_out, c_out;

    dct_accum_bank #(.N_CH(1), .N_TERMS(3), .ROUND_EN(0), .SAT_EN(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_start(s_start), .in_data(s_data),
        .out_valid(a_ov), .out_ch(a_ch), .out_data(a_out), .frame_done(a_fd),
        .ovf_sticky(a_ovf), .drop_err(a_drop)
    );

    dct_accum_bank #(.N_CH(1), .N_TERMS(2), .ROUND_EN(1), .SAT_EN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_start(s_start), .in_data(s_data),
        .out_valid(b_ov), .out_ch(b_ch), .out_data(b_out), .frame_done(b_fd),
        .ovf_sticky(b_ovf), .drop_err(b_drop)
    );

    dct_accum_bank #(.N_CH(1), .N_TERMS(3), .ROUND_EN(0), .SAT_EN(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_start(s_start), .in_data(s_data),
        .out_valid(c_ov), .out_ch(c_ch), .out_data(c_out), .frame_done(c_fd),
        .ovf_sticky(c_ovf), .drop_err(c_drop)
    );

    int total = 0;
    int bad   = 0;
    int xs[NS];
    int expv[N_CH];

    typedef struct {
        string name;
        int    sel;
        int    n;
        int    d0;
        int    d1;
        int    d2;
        int    exp_out;
    } svec_t;

    svec_t vecs[6];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Coefficient from a channel's exact sum: round half up at 2^8, floor, clamp to 16 bits.
    function automatic int ref_coef(input longint s);
        longint q;
        q = (s + 128) >>> 8;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    // Build one frame of samples and the expected coefficient per channel.
    task automatic gen_frame(input int mode, input int rng);
        for (int k = 0; k < NS; k++) begin
            if (mode == 0) xs[k] = (k % N_CH) * 256;
            else xs[k] = int'($urandom_range(0, 2 * rng)) - rng;
        end
        for (int c = 0; c < N_CH; c++) begin
            longint s;
            s = 0;
            for (int t = 0; t < N_TERMS; t++) s += longint'(xs[t * N_CH + c]);
            expv[c] = ref_coef(s);
        end
    endtask

    // Feed the first n_feed samples of xs with random stalls up to gap_max cycles.
    task automatic drive_frame(input int n_feed, input int gap_max);
        for (int k = 0; k < n_feed; k++) begin
            int g;
            int t;
            int c;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int i = 0; i < g; i++) begin
                m_valid = 1'b0;
                m_start = 1'b0;
                @(posedge clk); #1;
                chk("stall_vld", longint'(m_ov), 0);
            end
            m_valid = 1'b1;
            m_start = (k == 0);
            m_data  = 23'(xs[k]);
            @(posedge clk); #1;
            t = k / N_CH;
            c = k % N_CH;
            if (t == N_TERMS - 1) begin
                chk("out_vld", longint'(m_ov), 1);
                chk("out_ch", longint'(m_ch), longint'(c));
                chk("out_data", longint'(m_out), longint'(expv[c]));
                chk("frame_done", longint'(m_fd), (c == N_CH - 1) ? 1 : 0);
            end else begin
                chk("early_vld", longint'(m_ov), 0);
                chk("early_fd", longint'(m_fd), 0);
            end
        end
        m_valid = 1'b0;
        m_start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"basic3",   0, 3,     256,     512,    -256,      2};
        vecs[1] = '{"rnd_up",   1, 2,     256,     128,       0,      2};
        vecs[2] = '{"rnd_neg",  1, 2,    -256,    -128,       0,     -1};
        vecs[3] = '{"rnd_dn",   1, 2,     256,     127,       0,      1};
        vecs[4] = '{"sat_clmp", 2, 3, 4194303, 4194303, 4194303,  32767};
        vecs[5] = '{"sat_wrap", 0, 3, 4194303, 4194303, 4194303, -16385};

        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld",  longint'(m_ov), 0);
        chk("rst_ch",   longint'(m_ch), 0);
        chk("rst_data", longint'(m_out), 0);
        chk("rst_fd",   longint'(m_fd), 0);
        chk("rst_ovf",  longint'(m_ovf), 0);
        chk("rst_drop", longint'(m_drop), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single-channel table
        for (int v = 0; v < 6; v++) begin
            int d[3];
            d[0] = vecs[v].d0;
            d[1] = vecs[v].d1;
            d[2] = vecs[v].d2;
            for (int k = 0; k < vecs[v].n; k++) begin
                logic               ov, fd, ch;
                logic signed [15:0] od;
                s_valid = 1'b1;
                s_start = (k == 0);
                s_data  = 23'(d[k]);
                @(posedge clk); #1;
                case (vecs[v].sel)
                    0:       begin ov = a_ov; fd = a_fd; ch = a_ch; od = a_out; end
                    1:       begin ov = b_ov; fd = b_fd; ch = b_ch; od = b_out; end
                    default: begin ov = c_ov; fd = c_fd; ch = c_ch; od = c_out; end
                endcase
                if (k < vecs[v].n - 1) begin
                    chk({vecs[v].name, "_early"}, longint'(ov), 0);
                end else begin
                    chk({vecs[v].name, "_vld"}, longint'(ov), 1);
                    chk({vecs[v].name, "_data"}, longint'(od), longint'(vecs[v].exp_out));
                    chk({vecs[v].name, "_ch"}, longint'(ch), 0);
                    chk({vecs[v].name, "_fd"}, longint'(fd), 1);
                end
            end
            s_valid = 1'b0;
            s_start = 1'b0;
            @(posedge clk); #1;
        end

        // deterministic ramp frame back-to-back, then the same frame with stalls
        gen_frame(0, 0);
        drive_frame(NS, 0);
        drive_frame(NS, 3);

        // random frames: full range (saturating), small range back-to-back
        gen_frame(1, 4194303);
        drive_frame(NS, 2);
        gen_frame(1, 3000);
        drive_frame(NS, 0);
        gen_frame(1, 200000);
        drive_frame(NS, 1);
        chk("ovf_clear", longint'(m_ovf), 0);

        // sample in IDLE without start is dropped and flagged
        @(posedge clk); #1;
        m_valid = 1'b1;
        m_start = 1'b0;
        m_data  = 23'(12345);
        @(posedge clk); #1;
        chk("drop_pulse", longint'(m_drop), 1);
        chk("drop_vld",   longint'(m_ov), 0);
        m_valid = 1'b0;
        @(posedge clk); #1;
        chk("drop_clear", longint'(m_drop), 0);
        gen_frame(1, 50000);
        drive_frame(NS, 0);

        // abort at term 10, then a clean frame
        gen_frame(1, 100000);
        drive_frame(10 * N_CH + 3, 1);
        gen_frame(1, 100000);
        drive_frame(NS, 0);

        // reset in the middle of the output burst
        gen_frame(1, 8000);
        drive_frame((N_TERMS - 1) * N_CH + 6, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_vld",  longint'(m_ov), 0);
        chk("mrst_ch",   longint'(m_ch), 0);
        chk("mrst_data", longint'(m_out), 0);
        chk("mrst_fd",   longint'(m_fd), 0);
        chk("mrst_ovf",  longint'(m_ovf), 0);
        chk("mrst_drop", longint'(m_drop), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        gen_frame(1, 60000);
        drive_frame(NS, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
